// File: rtl/signal_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module  : signal_conditioner_pkg
// Purpose : FSM encoding, default parameters and a width helper for the
//           signal conditioner front end.
// Rev     : 1.0  initial release
// ============================================================================
package signal_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    localparam int unsigned c_DEF_SYNC_STAGES = 2;
    localparam int unsigned c_DEF_FILT_LEN    = 4;
    localparam int unsigned c_DEF_LOS_TIMEOUT = 50000000;
    localparam int unsigned c_DEF_CNT_W       = 32;

    // Bits needed to hold the values 0..max_val, never less than one.
    function automatic int unsigned width_for(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : signal_conditioner_pkg
`default_nettype wire

// File: rtl/signal_conditioner_sync_glitch_filter.sv
`default_nettype none
// ============================================================================
// Module  : sync_glitch_filter
// Purpose : Multi-flop synchroniser followed by a run-length glitch filter;
//           emits the filtered level and the cycle-before-change detects.
// Rev     : 1.0  initial release
// ============================================================================
module sync_glitch_filter
    import signal_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = c_DEF_SYNC_STAGES,
    parameter int unsigned FILT_LEN    = c_DEF_FILT_LEN
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic signal_i,
    output logic sig_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned c_FCW = width_for(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [c_FCW-1:0]       filt_cnt_q, filt_cnt_d;
    logic                   level_q, level_d;
    logic                   sync_out;

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], signal_i};
        sync_out   = sync_q[SYNC_STAGES-1];
        level_d    = level_q;
        filt_cnt_d = '0;
        rise_o     = 1'b0;
        fall_o     = 1'b0;
        // The level only moves once the new value has been seen FILT_LEN
        // cycles in a row; any agreeing sample restarts the run.
        if (sync_out != level_q) begin
            if (filt_cnt_q == c_FCW'(FILT_LEN - 1)) begin
                level_d = sync_out;
                rise_o  = sync_out;
                fall_o  = ~sync_out;
            end else begin
                filt_cnt_d = filt_cnt_q + c_FCW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync_q     <= '0;
            filt_cnt_q <= '0;
            level_q    <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            filt_cnt_q <= filt_cnt_d;
            level_q    <= level_d;
        end
    end

    assign sig_o = level_q;

endmodule : sync_glitch_filter
`default_nettype wire

// File: rtl/signal_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : signal_conditioner
// Purpose : Synchronise/deglitch the measured signal, strobe its edges, count
//           rises and flag loss of signal. Optional: SIGNAL_CONDITIONER_PRESCALER_EN
// Rev     : 1.0  initial release
// ============================================================================
module signal_conditioner
    import signal_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = c_DEF_SYNC_STAGES,
    parameter int unsigned FILT_LEN    = c_DEF_FILT_LEN,
    parameter int unsigned LOS_TIMEOUT = c_DEF_LOS_TIMEOUT,
    parameter int unsigned CNT_W       = c_DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             signal_i,
    input  logic             enable_i,
    input  logic             clr_i,
`ifdef SIGNAL_CONDITIONER_PRESCALER_EN
    input  logic [1:0]       prescale_sel_i,
`endif
    output logic             sig_o,
    output logic             rise_pulse_o,
    output logic             fall_pulse_o,
    output logic [CNT_W-1:0] edge_count_o,
    output logic             overflow_o,
    output logic             signal_present_o
);

    localparam int unsigned c_LOSW = width_for(LOS_TIMEOUT);

    logic              filt_rise;
    logic              filt_fall;
    logic              pre_fire;
    logic              los_expired;
    state_e            state_q, state_d;
    logic [c_LOSW-1:0] los_q, los_d;
    logic              rise_pulse_q, rise_pulse_d;
    logic              fall_pulse_q, fall_pulse_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;

    sync_glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_filter (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .signal_i (signal_i),
        .sig_o    (sig_o),
        .rise_o   (filt_rise),
        .fall_o   (filt_fall)
    );

`ifdef SIGNAL_CONDITIONER_PRESCALER_EN
    logic [2:0] pre_q, pre_d;
    logic [2:0] pre_last;
    logic [1:0] sel_q;

    always_comb begin
        pre_last = ~(3'b111 << sel_q);
        pre_d    = pre_q;
        pre_fire = 1'b0;
        if (state_q == IDLE || prescale_sel_i != sel_q) begin
            pre_d = '0;
        end else if (filt_rise) begin
            if (pre_q == pre_last) begin
                pre_fire = 1'b1;
                pre_d    = '0;
            end else begin
                pre_d = pre_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pre_q <= '0;
            sel_q <= '0;
        end else begin
            pre_q <= pre_d;
            sel_q <= prescale_sel_i;
        end
    end
`else
    assign pre_fire = filt_rise;
`endif

    always_comb begin
        los_expired = (los_q == c_LOSW'(LOS_TIMEOUT));
        state_d     = state_q;
        unique case (state_q)
            IDLE: begin
                if (enable_i) state_d = ACQUIRE;
            end
            ACQUIRE: begin
                if (!enable_i)     state_d = IDLE;
                else if (filt_rise) state_d = LOCKED;
            end
            LOCKED: begin
                // A rise in the timeout cycle keeps the lock.
                if (!enable_i)                       state_d = IDLE;
                else if (!filt_rise && los_expired) state_d = ACQUIRE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        los_d = los_q;
        if (state_q == IDLE || filt_rise) begin
            los_d = '0;
        end else if (!los_expired) begin
            los_d = los_q + c_LOSW'(1);
        end

        rise_pulse_d = (state_q != IDLE) && pre_fire;
        fall_pulse_d = (state_q != IDLE) && filt_fall;

        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr_i) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (rise_pulse_q) begin
            count_d = count_q + CNT_W'(1);
            if (&count_q) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            los_q        <= '0;
            rise_pulse_q <= 1'b0;
            fall_pulse_q <= 1'b0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            los_q        <= los_d;
            rise_pulse_q <= rise_pulse_d;
            fall_pulse_q <= fall_pulse_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
        end
    end

    assign rise_pulse_o     = rise_pulse_q;
    assign fall_pulse_o     = fall_pulse_q;
    assign edge_count_o     = count_q;
    assign overflow_o       = ovf_q;
    assign signal_present_o = (state_q == LOCKED);

endmodule : signal_conditioner
`default_nettype wire
